butterfly_mem_arb: RTL and testbench
====================================

# butterfly_mem_arb

Two-port to single-port memory arbiter for the ButterFly RV32IM SoC. It shares one single-port, one-cycle-latency unified SRAM between the core's instruction-fetch port and data port. Grants are combinational, with fixed data-over-fetch priority, and read responses are pipelined one cycle behind the grant. It sits between `butterfly_core` and the unified memory, replacing the separate instruction ROM and data stub.

## Interface
Parameters:
- `ADDR_W`, 14 — SRAM word-address width (2^ADDR_W 32-bit words).
- `STARVE_MAX`, 4 — consecutive denied fetch cycles before fetch is forced through (guard only).

Ports:
- `clk_i`  in  1  — single clock, rising edge.
- `rst_i`  in  1  — reset, asynchronous, active-high.
- `if_valid_i`  in  1  — fetch read request.
- `if_addr_i`  in  32  — fetch byte address.
- `if_ready_o`  out  1  — fetch request accepted this cycle.
- `if_rvalid_o`  out  1  — fetch read data valid.
- `if_rdata_o`  out  32  — fetch read data.
- `dm_valid_i`  in  1  — data request.
- `dm_we_i`  in  1  — 1 = write, 0 = read.
- `dm_addr_i`  in  32  — data byte address.
- `dm_wdata_i`  in  32  — write data.
- `dm_wstrb_i`  in  4  — byte write strobes.
- `dm_ready_o`  out  1  — data request accepted this cycle.
- `dm_rvalid_o`  out  1  — data read data valid (never pulses for writes).
- `dm_rdata_o`  out  32  — data read data.
- `mem_req_o`  out  1  — SRAM access this cycle.
- `mem_we_o`  out  1  — SRAM write enable.
- `mem_addr_o`  out  ADDR_W  — SRAM word address.
- `mem_wdata_o`  out  32  — SRAM write data.
- `mem_wstrb_o`  out  4  — SRAM byte strobes.
- `mem_rdata_i`  in  32  — SRAM read data, valid the cycle after a read request.

## Operation
**Request handshake**
- A requester holds valid, address and data stable until its ready is high.
- Ready is combinational from the valids and arbiter state; the transfer occurs on the cycle where valid and ready are both high.

**Arbitration**
- Default: `dm` wins over `if`. The loser's ready is 0 and its request stays pending.
- With the starvation guard enabled, `if` wins when the starvation counter equals `STARVE_MAX`.

**SRAM drive**
- `mem_req_o` = any grant this cycle.
- `mem_addr_o` = granted `addr[ADDR_W+1:2]`. Byte offset bits [1:0] and high address bits are ignored, so addresses alias.
- `mem_we_o`, `mem_wdata_o` and `mem_wstrb_o` come from `dm` when `dm` is granted. When `if` is granted: `we=0`, `wstrb=0`, `wdata=0`.
- All `mem_*` outputs are 0 when there is no grant.

**Response tracking**
- Register `rsp_q` is one of NONE, IF or DM_RD.
- Each clock, `rsp_q` is loaded with the owner of the read granted this cycle. A `dm` write or no grant loads NONE.
- `if_rvalid_o = (rsp_q==IF)`; `dm_rvalid_o = (rsp_q==DM_RD)`.
- Each rdata output = `mem_rdata_i` when its rvalid is high, else 32'h0.

**Back-to-back traffic**
- A new grant may be issued in the same cycle a prior response is returned, giving full throughput of one access per cycle.

**Reset**
- Reset is asynchronous, and can occur mid-transaction.
- On reset: `rsp_q`=NONE, starvation counter = 0, all rvalid outputs 0, all rdata outputs 0. Any response in flight is dropped.
- The combinational outputs (`mem_*`, ready) follow the inputs even while in reset.

## Timing
- Grant latency: 0 cycles. Ready rises in the same cycle as valid if that requester wins.
- Read latency: rvalid and rdata appear exactly 1 cycle after the accepting cycle.
- Write: completes at the accepting edge; no response.
- Simultaneous `if` and `dm` requests: `dm` is granted in cycle N. `if` is granted in cycle N+1 unless `dm` requests again.
- No combinational path from `mem_rdata_i` to any ready.

## Configuration
- `BFLY_ARB_STARVE_GUARD_EN` defined:
  - Adds a saturating counter of width `$clog2(STARVE_MAX+1)`.
  - The counter increments each cycle `if_valid_i && !if_ready_o` and clears to 0 on a fetch grant.
  - At `STARVE_MAX`, `if` takes priority over `dm` for one grant.
- Not defined: strict `dm` priority. There is no counter, and `if` can starve indefinitely.

## Structure
- `butterfly_pkg` holds the response-owner enum `arb_rsp_e` {NONE, IF, DM_RD} and `XLEN`=32.
- One sub-module, `butterfly_arb_starve_ctr`, is instantiated only under the macro. Its ports are `clk_i`, `rst_i`, `wait_i`, `clr_i` and `force_o`.

## Test plan
- Reset: hold `rst_i`=1 with both valids high → all rvalid=0, rdata=0. `mem_req_o` follows the combinational grant.
- Fetch only: `if` reads 0x100 with SRAM word 0x40 = 0xDEADBEEF → `mem_addr_o`=0x40 in cycle N; `if_rvalid_o`=1 and `if_rdata_o`=0xDEADBEEF in N+1.
- Collision: `if` and `dm` read together (0x0, 0x8) for one cycle → `dm` granted in N and `if` in N+1. `dm_rvalid_o` pulses in N+1 and `if_rvalid_o` in N+2.
- Write: `dm` write to 0x204 with `wstrb`=4'b0011 and data 0x12345678 → `mem_we_o`=1, `mem_addr_o`=0x81, `mem_wstrb_o`=0011. No `dm_rvalid_o` pulse follows.
- Starvation (guard on, `STARVE_MAX`=4): `dm` and `if` valid continuously → `dm` granted for 4 cycles, then `if` for 1, repeating. With the guard off, `if_ready_o` stays 0 throughout.
- Async reset asserted between a read grant and its response → no rvalid pulse. The next grant after reset behaves normally.

Source files
------------

// File: rtl/butterfly_pkg.sv
// butterfly_pkg: shared types and constants for the ButterFly memory arbiter.
//   XLEN       - datapath width (32).
//   arb_rsp_e  - owner of the read response in flight (NONE, IF, DM_RD).
package butterfly_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        IF    = 2'd1,
        DM_RD = 2'd2
    } arb_rsp_e;

endpackage

// File: rtl/butterfly_mem_arb_if.sv
// butterfly_mem_arb_if: bundle of the fetch port, data port and SRAM port
// around butterfly_mem_arb.
//   slave  - arbiter view: consumes fetch/data requests and SRAM read data,
//            drives readies, responses and the SRAM request.
//   master - surrounding view (core + SRAM): the mirror image.
interface butterfly_mem_arb_if
    import butterfly_pkg::*;
#(
    parameter int ADDR_W = 14
);
    // fetch port
    logic              if_valid_i;
    logic [XLEN-1:0]   if_addr_i;
    logic              if_ready_o;
    logic              if_rvalid_o;
    logic [XLEN-1:0]   if_rdata_o;
    // data port
    logic              dm_valid_i;
    logic              dm_we_i;
    logic [XLEN-1:0]   dm_addr_i;
    logic [XLEN-1:0]   dm_wdata_i;
    logic [3:0]        dm_wstrb_i;
    logic              dm_ready_o;
    logic              dm_rvalid_o;
    logic [XLEN-1:0]   dm_rdata_o;
    // SRAM port
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [XLEN-1:0]   mem_wdata_o;
    logic [3:0]        mem_wstrb_o;
    logic [XLEN-1:0]   mem_rdata_i;

    modport slave (
        input  if_valid_i, if_addr_i,
        output if_ready_o, if_rvalid_o, if_rdata_o,
        input  dm_valid_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_wstrb_i,
        output dm_ready_o, dm_rvalid_o, dm_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        input  mem_rdata_i
    );

    modport master (
        output if_valid_i, if_addr_i,
        input  if_ready_o, if_rvalid_o, if_rdata_o,
        output dm_valid_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_wstrb_i,
        input  dm_ready_o, dm_rvalid_o, dm_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        output mem_rdata_i
    );

endinterface

// File: rtl/butterfly_arb_starve_ctr.sv
// butterfly_arb_starve_ctr: saturating count of consecutive denied fetch
// cycles. Only instantiated when BFLY_ARB_STARVE_GUARD_EN is defined.
//   clk_i   - clock, rising edge
//   rst_i   - asynchronous active-high reset (count -> 0)
//   wait_i  - fetch requesting but not granted this cycle
//   clr_i   - fetch granted this cycle (count -> 0)
//   force_o - count reached STARVE_MAX: fetch must win the next grant
module butterfly_arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic wait_i,
    input  logic clr_i,
    output logic force_o
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] MAXV = CW'(STARVE_MAX);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (wait_i && (r_cnt != MAXV)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign force_o = (r_cnt == MAXV);

endmodule

// File: rtl/butterfly_mem_arb.sv
// butterfly_mem_arb: shares one single-port, one-cycle-latency SRAM between
// the core fetch port and data port. Grants are combinational with data
// priority; read data returns one cycle after the grant.
// Optional feature macro: BFLY_ARB_STARVE_GUARD_EN (fetch starvation guard).
//   clk_i - clock, rising edge
//   rst_i - asynchronous active-high reset
//   bus   - butterfly_mem_arb_if.slave: fetch port (if_*), data port (dm_*),
//           SRAM port (mem_*)
module butterfly_mem_arb
    import butterfly_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    butterfly_mem_arb_if.slave  bus
);

    logic     w_if_gnt;
    logic     w_dm_gnt;
    arb_rsp_e r_rsp_q;
    arb_rsp_e w_rsp_d;

`ifdef BFLY_ARB_STARVE_GUARD_EN
    logic w_force;

    butterfly_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wait_i  (bus.if_valid_i && !w_if_gnt),
        .clr_i   (w_if_gnt),
        .force_o (w_force)
    );

    // Saturated counter hands fetch exactly one grant, then clears.
    assign w_if_gnt = bus.if_valid_i && (!bus.dm_valid_i || w_force);
`else
    localparam int starve_max_unused = STARVE_MAX;

    assign w_if_gnt = bus.if_valid_i && !bus.dm_valid_i;
`endif

    assign w_dm_gnt = bus.dm_valid_i && !w_if_gnt;

    // Address bits outside the word index are ignored (addresses alias).
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{bus.if_addr_i[XLEN-1:ADDR_W+2], bus.if_addr_i[1:0],
                                  bus.dm_addr_i[XLEN-1:ADDR_W+2], bus.dm_addr_i[1:0]};

    // Response owner register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rsp_q <= NONE;
        end else begin
            r_rsp_q <= w_rsp_d;
        end
    end

    // Next response owner: only reads produce a response
    always_comb begin
        w_rsp_d = NONE;
        if (w_dm_gnt && !bus.dm_we_i) begin
            w_rsp_d = DM_RD;
        end else if (w_if_gnt) begin
            w_rsp_d = IF;
        end
    end

    // Outputs: grants, SRAM drive, response steering
    always_comb begin
        bus.if_ready_o  = w_if_gnt;
        bus.dm_ready_o  = w_dm_gnt;
        bus.mem_req_o   = w_if_gnt || w_dm_gnt;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.mem_wstrb_o = '0;
        if (w_dm_gnt) begin
            bus.mem_we_o    = bus.dm_we_i;
            bus.mem_addr_o  = bus.dm_addr_i[ADDR_W+1:2];
            bus.mem_wdata_o = bus.dm_wdata_i;
            bus.mem_wstrb_o = bus.dm_wstrb_i;
        end else if (w_if_gnt) begin
            bus.mem_addr_o  = bus.if_addr_i[ADDR_W+1:2];
        end

        bus.if_rvalid_o = (r_rsp_q == IF);
        bus.dm_rvalid_o = (r_rsp_q == DM_RD);
        bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_rdata_i : '0;
        bus.dm_rdata_o  = bus.dm_rvalid_o ? bus.mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_butterfly_mem_arb.sv
// tb_butterfly_mem_arb: directed, table-driven bench for butterfly_mem_arb
// with a behavioural one-cycle-latency SRAM attached to the mem_* port.
module tb_butterfly_mem_arb;

`ifdef BFLY_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;

    butterfly_mem_arb_if #(.ADDR_W(14)) bus ();

    butterfly_mem_arb #(
        .ADDR_W     (14),
        .STARVE_MAX (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model
    logic [31:0] sram [0:16383];
    logic [31:0] r_rdq;
    assign bus.mem_rdata_i = r_rdq;

    always @(posedge clk) begin
        if (bus.mem_req_o) begin
            if (bus.mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wstrb_o[b]) sram[bus.mem_addr_o][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
            end else begin
                r_rdq <= sram[bus.mem_addr_o];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ifv, input logic [31:0] ifa, input logic dmv, input logic we,
                         input logic [31:0] dma, input logic [31:0] wd, input logic [3:0] ws);
        bus.if_valid_i = ifv;
        bus.if_addr_i  = ifa;
        bus.dm_valid_i = dmv;
        bus.dm_we_i    = we;
        bus.dm_addr_i  = dma;
        bus.dm_wdata_i = wd;
        bus.dm_wstrb_i = ws;
    endtask

    typedef struct {
        logic        ifv;
        logic [31:0] ifa;
        logic        dmv;
        logic        we;
        logic [31:0] dma;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        e_ifr;
        logic        e_dmr;
        logic        e_req;
        logic        e_we;
        logic [13:0] e_addr;
        logic [31:0] e_wd;
        logic [3:0]  e_ws;
        logic        e_ifrv;
        logic        e_dmrv;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic        p_ifrv;
        logic        p_dmrv;
        logic [31:0] p_rd;
        logic        exp_dm;

        total = 0;
        bad   = 0;

        for (int i = 0; i < 16384; i++) sram[i] = 32'h0;
        sram[14'h000] = 32'h11110000;
        sram[14'h002] = 32'h22220002;
        sram[14'h040] = 32'hDEADBEEF;
        sram[14'h041] = 32'hCAFEF00D;
        r_rdq = 32'h0;

        //          ifv ifa            dmv we dma            wd             ws       ifr dmr req we addr      wd             ws       ifrv dmrv rd
        tbl[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        4'h0,   1'b0,1'b0,1'b0,1'b0,14'h00, 32'h0,        4'h0,   1'b0,1'b0,32'h0};
        tbl[1]  = '{1'b1, 32'h100,      1'b0, 1'b0, 32'h0,        32'h0,        4'h0,   1'b1,1'b0,1'b1,1'b0,14'h40, 32'h0,        4'h0,   1'b1,1'b0,32'hDEADBEEF};
        tbl[2]  = '{1'b1, 32'h0,        1'b1, 1'b0, 32'h8,        32'h0,        4'h0,   1'b0,1'b1,1'b1,1'b0,14'h02, 32'h0,        4'h0,   1'b0,1'b1,32'h22220002};
        tbl[3]  = '{1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        4'h0,   1'b1,1'b0,1'b1,1'b0,14'h00, 32'h0,        4'h0,   1'b1,1'b0,32'h11110000};
        tbl[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h204,      32'h12345678, 4'b0011,1'b0,1'b1,1'b1,1'b1,14'h81, 32'h12345678, 4'b0011,1'b0,1'b0,32'h0};
        tbl[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h204,      32'h0,        4'h0,   1'b0,1'b1,1'b1,1'b0,14'h81, 32'h0,        4'h0,   1'b0,1'b1,32'h00005678};
        tbl[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'hFFFF0107, 32'h0,        4'h0,   1'b0,1'b1,1'b1,1'b0,14'h41, 32'h0,        4'h0,   1'b0,1'b1,32'hCAFEF00D};
        tbl[7]  = '{1'b1, 32'h100,      1'b1, 1'b1, 32'h8,        32'hAAAA5555, 4'hF,   1'b0,1'b1,1'b1,1'b1,14'h02, 32'hAAAA5555, 4'hF,   1'b0,1'b0,32'h0};
        tbl[8]  = '{1'b1, 32'h100,      1'b0, 1'b1, 32'h8,        32'h99999999, 4'hF,   1'b1,1'b0,1'b1,1'b0,14'h40, 32'h0,        4'h0,   1'b1,1'b0,32'hDEADBEEF};
        tbl[9]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        32'h99999999, 4'hF,   1'b0,1'b0,1'b0,1'b0,14'h00, 32'h0,        4'h0,   1'b0,1'b0,32'h0};
        tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h8,        32'h0,        4'h0,   1'b0,1'b1,1'b1,1'b0,14'h02, 32'h0,        4'h0,   1'b0,1'b1,32'hAAAA5555};
        tbl[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        4'h0,   1'b0,1'b0,1'b0,1'b0,14'h00, 32'h0,        4'h0,   1'b0,1'b0,32'h0};

        // Reset held with both valids high: responses stay off, grant is live
        rst = 1'b1;
        drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_if_rvalid", bus.if_rvalid_o, 1'b0);
        check("rst_dm_rvalid", bus.dm_rvalid_o, 1'b0);
        check("rst_if_rdata",  bus.if_rdata_o,  32'h0);
        check("rst_dm_rdata",  bus.dm_rdata_o,  32'h0);
        check("rst_mem_req",   bus.mem_req_o,   1'b1);
        check("rst_dm_ready",  bus.dm_ready_o,  1'b1);
        check("rst_if_ready",  bus.if_ready_o,  1'b0);
        check("rst_mem_addr",  bus.mem_addr_o,  14'h02);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Table: one vector per cycle; responses checked against the previous row
        p_ifrv = 1'b0;
        p_dmrv = 1'b0;
        p_rd   = 32'h0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(tbl[i].ifv, tbl[i].ifa, tbl[i].dmv, tbl[i].we, tbl[i].dma, tbl[i].wd, tbl[i].ws);
            #1;
            check($sformatf("v%0d_if_ready", i),  bus.if_ready_o,  tbl[i].e_ifr);
            check($sformatf("v%0d_dm_ready", i),  bus.dm_ready_o,  tbl[i].e_dmr);
            check($sformatf("v%0d_mem_req", i),   bus.mem_req_o,   tbl[i].e_req);
            check($sformatf("v%0d_mem_we", i),    bus.mem_we_o,    tbl[i].e_we);
            check($sformatf("v%0d_mem_addr", i),  bus.mem_addr_o,  tbl[i].e_addr);
            check($sformatf("v%0d_mem_wdata", i), bus.mem_wdata_o, tbl[i].e_wd);
            check($sformatf("v%0d_mem_wstrb", i), bus.mem_wstrb_o, tbl[i].e_ws);
            check($sformatf("v%0d_if_rvalid", i), bus.if_rvalid_o, p_ifrv);
            check($sformatf("v%0d_dm_rvalid", i), bus.dm_rvalid_o, p_dmrv);
            check($sformatf("v%0d_if_rdata", i),  bus.if_rdata_o,  p_ifrv ? p_rd : 32'h0);
            check($sformatf("v%0d_dm_rdata", i),  bus.dm_rdata_o,  p_dmrv ? p_rd : 32'h0);
            p_ifrv = tbl[i].e_ifrv;
            p_dmrv = tbl[i].e_dmrv;
            p_rd   = tbl[i].e_rd;
        end
        @(negedge clk);
        #1;
        check("tail_if_rvalid", bus.if_rvalid_o, p_ifrv);
        check("tail_dm_rvalid", bus.dm_rvalid_o, p_dmrv);

        // Async reset between a read grant and its response drops the response
        @(negedge clk);
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("ar_if_ready", bus.if_ready_o, 1'b1);
        @(posedge clk);
        #1;
        check("ar_pre_rvalid", bus.if_rvalid_o, 1'b1);
        #1;
        rst = 1'b1;
        bus.if_valid_i = 1'b0;
        #1;
        check("ar_drop_rvalid", bus.if_rvalid_o, 1'b0);
        check("ar_drop_rdata",  bus.if_rdata_o,  32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("ar_after_rvalid", bus.if_rvalid_o, 1'b0);
        bus.if_valid_i = 1'b1;
        #1;
        check("ar_regrant_ready", bus.if_ready_o, 1'b1);
        @(negedge clk);
        bus.if_valid_i = 1'b0;
        #1;
        check("ar_regrant_rvalid", bus.if_rvalid_o, 1'b1);
        check("ar_regrant_rdata",  bus.if_rdata_o,  32'hDEADBEEF);

        // Both ports requesting continuously
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
            #1;
            exp_dm = GUARD ? ((k % 5) != 4) : 1'b1;
            check($sformatf("st%0d_dm_ready", k), bus.dm_ready_o, exp_dm);
            check($sformatf("st%0d_if_ready", k), bus.if_ready_o, !exp_dm);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
